spike_rate_decoder: RTL
=======================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the spike count, interval and window fields.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  input  1  high = decoding enabled; low = return to IDLE.
REQ-005 SHALL have port spike_in  input  1  neuron spike output (uo_out[0] of the neuron), level, may stay high for several cycles.
REQ-006 SHALL have port window_len  input  CNT_W  window length minus one, in clk cycles.
REQ-007 SHALL have port out_valid  output  1  result holding register is full.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-009 SHALL have port out_count  output  CNT_W  spikes (rising edges) in the completed window, saturating.
REQ-010 SHALL have port out_isi  output  CNT_W  last completed inter-spike interval in cycles, saturating; 0 = fewer than two spikes since reset.
REQ-011 SHALL have port overrun  output  1  sticky: a completed window result was dropped.

Function
REQ-012 SHALL detect a spike as a rising edge: spike_in high and spike_in registered one cycle earlier low; a level held high counts once.
REQ-013 SHALL implement FSM states IDLE, COUNT; IDLE->COUNT when en=1; COUNT->IDLE when en=0, discarding the partial window, with no result produced.
REQ-014 SHALL latch window_len on entry to COUNT and at each window start; changes mid-window do not affect the current window.
REQ-015 SHALL count window cycles 0..window_len; a window spans window_len+1 cycles (window_len=0 gives 1-cycle windows).
REQ-016 SHALL include an edge detected in the last window cycle in that window's count; the next window starts at 0 in the following cycle.
REQ-017 SHALL saturate the spike count at 2^CNT_W-1.
REQ-018 SHALL measure ISI as cycles between consecutive rising edges (edges in cycles t and t+k give ISI k), saturating at 2^CNT_W-1; the ISI counter continues across window boundaries and in IDLE.
REQ-019 SHALL, one cycle after a window's last cycle, load out_count and out_isi into the holding register and assert out_valid, if the register is empty or is being accepted in that same cycle.
REQ-020 SHALL, when a window completes while out_valid=1 and out_ready=0, keep the held result unchanged, drop the new one and set overrun.
REQ-021 SHALL hold out_count and out_isi stable while out_valid=1 and out_ready=0.
REQ-022 SHALL deassert out_valid the cycle after acceptance unless a new result loads in that cycle.
REQ-023 SHALL keep out_valid and the held result unaffected by en deassertion; a held result remains available in IDLE.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE and clear out_valid, out_count, out_isi, overrun, window and ISI counters, the edge-detect register and the ISI-seen flag.
REQ-025 SHALL let rst take priority over every other input, including mid-window and while a result is held.

Structure
REQ-026 SHALL take the FSM state enum and the default CNT_W from shared package tt_neuron_pkg.
REQ-027 SHALL use one sub-module, sat_counter (CNT_W-bit, clear/increment, saturating), instantiated for the spike count, window and ISI counters.
REQ-028 SHALL contain no combinational path from spike_in to any output.

Verification
REQ-029 SHALL verify: window_len=9, edges at cycles 1,4,7 of the window, out_ready=1 -> out_valid one cycle after window end with out_count=3, out_isi=3.
REQ-030 SHALL verify: spike_in held high 5 cycles inside one window -> out_count=1.
REQ-031 SHALL verify: window_len=3, out_ready=0 for two windows -> first result held and unchanged, overrun=1; after out_ready=1 for one cycle, out_valid=0.
REQ-032 SHALL verify: window_len=255, spike toggling every cycle (128 edges) and a 300-cycle gap before the next edge -> out_count=128, next out_isi=255.
REQ-033 SHALL verify: edge exactly in the last window cycle -> counted in that window, not the next; window_len=0 with a single edge -> out_count=1.
REQ-034 SHALL verify: rst=1 mid-window with out_valid=1 -> next cycle out_valid=0, overrun=0, out_count=0, out_isi=0; en low mid-window -> no result emitted.

Source files
------------

// File: rtl/tt_neuron_pkg.sv
// Shared definitions for the neuron spike decoders: decoder FSM states and
// the default width of count, interval and window fields.
package tt_neuron_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } dec_state_e;

endpackage

// File: rtl/sat_counter.sv
// W-bit up counter with synchronous clear and saturation at all-ones.
// Clear takes priority over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spike rising edges per window of window_len+1 cycles,
// tracks the last inter-spike interval, and hands results over a valid/ready holding register.
module spike_rate_decoder
   import tt_neuron_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_in,
   input  logic [CNT_W-1:0] window_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [CNT_W-1:0] out_isi,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] MAX = '1;

   dec_state_e       state_q;
   logic [CNT_W-1:0] len_q;
   logic             spike_q;
   logic             seen_q;
   logic [CNT_W-1:0] last_isi_q;
   logic             valid_q;
   logic             overrun_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic [CNT_W-1:0] hold_isi_q;

   logic             edge_s;
   logic             run_s;
   logic             win_last_s;
   logic             accept_s;
   logic [CNT_W-1:0] win_cnt_s;
   logic [CNT_W-1:0] spk_cnt_s;
   logic [CNT_W-1:0] isi_cnt_s;
   logic [CNT_W-1:0] isi_new_s;
   logic [CNT_W-1:0] res_cnt_s;
   logic [CNT_W-1:0] res_isi_s;

   assign edge_s     = spike_in & ~spike_q;
   assign run_s      = (state_q == ST_COUNT) & en;
   assign win_last_s = run_s & (win_cnt_s == len_q);
   assign accept_s   = valid_q & out_ready;

   sat_counter #(.W(CNT_W)) u_win_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (~run_s | win_last_s),
      .inc_i (run_s),
      .cnt_o (win_cnt_s)
   );

   sat_counter #(.W(CNT_W)) u_spk_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (~run_s | win_last_s),
      .inc_i (run_s & edge_s),
      .cnt_o (spk_cnt_s)
   );

   // Counts cycles since the last edge minus one; the interval is this plus one.
   sat_counter #(.W(CNT_W)) u_isi_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (edge_s),
      .inc_i (1'b1),
      .cnt_o (isi_cnt_s)
   );

   assign isi_new_s = (isi_cnt_s == MAX) ? MAX : (isi_cnt_s + ONE);
   assign res_isi_s = (edge_s && seen_q) ? isi_new_s : last_isi_q;
   assign res_cnt_s = (edge_s && (spk_cnt_s != MAX)) ? (spk_cnt_s + ONE) : spk_cnt_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  state_q <= ST_COUNT;
                  len_q   <= window_len;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_COUNT: begin
               if (!en) begin
                  state_q <= ST_IDLE;
               end else if (win_last_s) begin
                  len_q <= window_len;
               end else begin
                  state_q <= ST_COUNT;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spike_q    <= 1'b0;
         seen_q     <= 1'b0;
         last_isi_q <= '0;
      end else begin
         spike_q <= spike_in;
         if (edge_s) begin
            seen_q     <= 1'b1;
            last_isi_q <= res_isi_s;
         end else begin
            seen_q <= seen_q;
         end
      end
   end

   // A finished window loads only into an empty or draining register; otherwise it is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         hold_cnt_q <= '0;
         hold_isi_q <= '0;
      end else if (win_last_s) begin
         if (!valid_q || out_ready) begin
            valid_q    <= 1'b1;
            hold_cnt_q <= res_cnt_s;
            hold_isi_q <= res_isi_s;
         end else begin
            overrun_q <= 1'b1;
         end
      end else if (accept_s) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_q;
      end
   end

   assign out_valid = valid_q;
   assign out_count = hold_cnt_q;
   assign out_isi   = hold_isi_q;
   assign overrun   = overrun_q;

endmodule
